// File: rtl/bitmap_sprite_ctrl.sv
// -----------------------------------------------------------------------------
// bitmap_sprite_ctrl
//
// Bouncing 128x128 bitmap sprite. The sprite moves across the active area
// once per frame and reverses direction at each screen edge. The pixel path
// turns the beam position into a ROM address and gates the ROM bit with a
// window flag. The result lands two cycles after hpos/vpos.
//
// Ports
//   clk         single clock for all state
//   reset       synchronous, active-high; overrides a simultaneous frame_tick
//   hpos, vpos  current beam column / line (10 bits each)
//   frame_tick  one-cycle pulse per frame (vertical blanking): motion step
//   pause       freezes motion while high
//   rom_x/rom_y registered bitmap column/row address to the external ROM
//   rom_pixel   combinational ROM data for the current rom_x/rom_y
//   sprite_on   sprite pixel lit at the (two-cycle delayed) beam position
//   color       sprite colour index, cycles 1..7 and is never 0
//   bounce      one-cycle pulse after a tick that hit any edge
// -----------------------------------------------------------------------------
module bitmap_sprite_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SPEED    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       frame_tick,
  input  logic       pause,
  output logic [6:0] rom_x,
  output logic [6:0] rom_y,
  input  logic       rom_pixel,
  output logic       sprite_on,
  output logic [2:0] color,
  output logic       bounce
);

  localparam int          SPRITE = 128;
  localparam logic [9:0]  XMAX   = 10'(H_ACTIVE - SPRITE);
  localparam logic [9:0]  YMAX   = 10'(V_ACTIVE - SPRITE);
  localparam logic [10:0] STEP   = 11'(SPEED);

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       hit;
  } axis_t;

  // One motion step on one axis. A step that would reach or pass the limit
  // lands exactly on it, so the position never leaves 0..lim.
  function automatic axis_t axis_step(logic [9:0] pos, logic dir, logic [9:0] lim);
    axis_t      r;
    logic [10:0] fwd;
    fwd   = {1'b0, pos} + STEP;
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    if (dir) begin
      if (fwd >= {1'b0, lim}) begin
        r.pos = lim;
        r.dir = 1'b0;
        r.hit = 1'b1;
      end else begin
        r.pos = fwd[9:0];
      end
    end else begin
      if ({1'b0, pos} <= STEP) begin
        r.pos = '0;
        r.dir = 1'b1;
        r.hit = 1'b1;
      end else begin
        r.pos = pos - STEP[9:0];
      end
    end
    return r;
  endfunction

  // Colour sequence 1..7 then back to 1; zero is skipped.
  function automatic logic [2:0] color_next(logic [2:0] c);
    return (c == 3'd7) ? 3'd1 : c + 3'd1;
  endfunction

  // Motion state
  logic [9:0] pos_x, pos_y;
  logic       dir_x, dir_y;
  logic [2:0] color_q;
  logic       bounce_q;

  // Pixel pipeline registers
  logic [6:0] rom_x_p1, rom_y_p1;
  logic       vld_p1;
  logic       sprite_on_p2;

  // Stage p0: beam offset relative to the sprite origin. Offsets are signed
  // 12-bit so neither a beam left of the sprite nor pos+128 can wrap.
  logic signed [11:0] dx_p0, dy_p0;
  logic               win_p0;

  always_comb begin
    dx_p0  = $signed({2'b00, hpos}) - $signed({2'b00, pos_x});
    dy_p0  = $signed({2'b00, vpos}) - $signed({2'b00, pos_y});
    win_p0 = (dx_p0 >= 12'sd0) && (dx_p0 < 12'sd128) &&
             (dy_p0 >= 12'sd0) && (dy_p0 < 12'sd128);
  end

  axis_t ax, ay;
  logic  move;

  always_comb begin
    move = frame_tick & ~pause;
    ax   = axis_step(pos_x, dir_x, XMAX);
    ay   = axis_step(pos_y, dir_y, YMAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_x_p1     <= '0;
      rom_y_p1     <= '0;
      vld_p1       <= 1'b0;
      sprite_on_p2 <= 1'b0;
      pos_x        <= '0;
      pos_y        <= '0;
      dir_x        <= 1'b1;
      dir_y        <= 1'b1;
      color_q      <= 3'd1;
      bounce_q     <= 1'b0;
    end else begin
      // ---- stage p0 -> p1: ROM address and window flag ----
      rom_x_p1 <= dx_p0[6:0];
      rom_y_p1 <= dy_p0[6:0];
      vld_p1   <= win_p0;
      // ---- stage p1 -> p2: gate ROM data with the window ----
      sprite_on_p2 <= vld_p1 & rom_pixel;

      bounce_q <= 1'b0;
      if (move) begin
        pos_x <= ax.pos;
        dir_x <= ax.dir;
        pos_y <= ay.pos;
        dir_y <= ay.dir;
        // A corner hit counts as a single bounce.
        if (ax.hit | ay.hit) begin
          bounce_q <= 1'b1;
          color_q  <= color_next(color_q);
        end
      end
    end
  end

  assign rom_x     = rom_x_p1;
  assign rom_y     = rom_y_p1;
  assign sprite_on = sprite_on_p2;
  assign color     = color_q;
  assign bounce    = bounce_q;

endmodule

// File: tb/tb_bitmap_sprite_ctrl.sv
`timescale 1ns/1ps
module tb_bitmap_sprite_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, frame_tick, pause;
  logic [9:0] hpos, vpos;
  logic [6:0] rom_x_a, rom_y_a, rom_x_b, rom_y_b;
  logic       rom_pixel_a, rom_pixel_b;
  logic       sprite_on_a, sprite_on_b, bounce_a, bounce_b;
  logic [2:0] color_a, color_b;

  // Bitmap content used by both instances.
  function automatic logic rom_bit(logic [6:0] x, logic [6:0] y);
    return x[0] ^ y[0] ^ x[4];
  endfunction

  assign rom_pixel_a = rom_bit(rom_x_a, rom_y_a);
  assign rom_pixel_b = rom_bit(rom_x_b, rom_y_b);

  // Default 640x480 instance: full pixel path and motion checks.
  bitmap_sprite_ctrl u_dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .frame_tick(frame_tick), .pause(pause),
    .rom_x(rom_x_a), .rom_y(rom_y_a), .rom_pixel(rom_pixel_a),
    .sprite_on(sprite_on_a), .color(color_a), .bounce(bounce_a)
  );

  // Square 640x640 instance: both axes reach 512 on the same tick (corner).
  bitmap_sprite_ctrl #(.H_ACTIVE(640), .V_ACTIVE(640), .SPEED(1)) u_sq (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .frame_tick(frame_tick), .pause(pause),
    .rom_x(rom_x_b), .rom_y(rom_y_b), .rom_pixel(rom_pixel_b),
    .sprite_on(sprite_on_b), .color(color_b), .bounce(bounce_b)
  );

  localparam int SPD = 1;

  typedef struct {
    int x; int y; bit dx; bit dy; int col;
  } mst_t;

  typedef struct {
    int rx; int ry; bit ba; int ca; int rxb; int ryb; bit bb; int cb; bit win;
  } exp_t;

  typedef struct {
    bit v; bit s;
  } sexp_t;

  mst_t  ma, mb;
  exp_t  q1[$];
  sexp_t qs[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  bit    tick_hit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic axis_ref(inout int p, inout bit d, input int lim, output bit hit);
    hit = 1'b0;
    if (d) begin
      if (p + SPD >= lim) begin p = lim; d = 1'b0; hit = 1'b1; end
      else p = p + SPD;
    end else begin
      if (p <= SPD) begin p = 0; d = 1'b1; hit = 1'b1; end
      else p = p - SPD;
    end
  endtask

  task automatic advance(inout mst_t s, input int xmax, input int ymax, output bit b);
    int px, py; bit ddx, ddy, hx, hy;
    px = s.x; py = s.y; ddx = s.dx; ddy = s.dy;
    axis_ref(px, ddx, xmax, hx);
    axis_ref(py, ddy, ymax, hy);
    s.x = px; s.y = py; s.dx = ddx; s.dy = ddy;
    b = hx | hy;
    if (b) s.col = (s.col == 7) ? 1 : s.col + 1;
  endtask

  function automatic bit in_win(int hp, int vp, mst_t s);
    return (hp >= s.x) && (hp < s.x + 128) && (vp >= s.y) && (vp < s.y + 128);
  endfunction

  // Drive one cycle, push the expected post-edge results, then pop and compare.
  task automatic drive(input int hp, input int vp, input bit ft, input bit ps, input bit rst);
    exp_t  e, g;
    sexp_t se, sg;
    bit    ha, hb;
    hpos = 10'(hp); vpos = 10'(vp); frame_tick = ft; pause = ps; reset = rst;
    ha = 1'b0; hb = 1'b0;
    if (rst) begin
      e.rx = 0; e.ry = 0; e.rxb = 0; e.ryb = 0; e.win = 1'b0;
      ma = '{x:0, y:0, dx:1'b1, dy:1'b1, col:1};
      mb = '{x:0, y:0, dx:1'b1, dy:1'b1, col:1};
      se = qs[0]; se.v = 1'b1; se.s = 1'b0; qs[0] = se;
    end else begin
      e.win = in_win(hp, vp, ma);
      e.rx  = (hp - ma.x) & 127;
      e.ry  = (vp - ma.y) & 127;
      e.rxb = (hp - mb.x) & 127;
      e.ryb = (vp - mb.y) & 127;
      if (ft && !ps) begin
        advance(ma, 512, 352, ha);
        advance(mb, 512, 512, hb);
      end
    end
    e.ba = ha; e.bb = hb; e.ca = ma.col; e.cb = mb.col;
    tick_hit = ha;
    q1.push_back(e);
    se.v = 1'b1;
    se.s = e.win & rom_bit(7'(e.rx), 7'(e.ry));
    qs.push_back(se);
    @(posedge clk);
    #1;
    g = q1.pop_front();
    check("rom_x", rom_x_a, g.rx);
    check("rom_y", rom_y_a, g.ry);
    check("color", color_a, g.ca);
    check("bounce", bounce_a, g.ba);
    check("sq_rom_x", rom_x_b, g.rxb);
    check("sq_rom_y", rom_y_b, g.ryb);
    check("sq_color", color_b, g.cb);
    check("sq_bounce", bounce_b, g.bb);
    sg = qs.pop_front();
    if (sg.v) check("sprite_on", sprite_on_a, sg.s);
  endtask

  function automatic int near(int p);
    int v;
    v = p + int'($urandom_range(0, 140)) - 6;
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return v;
  endfunction

  // One motion tick with the beam roaming near the sprite, then an idle cycle.
  task automatic tick_once();
    bit h;
    drive(near(ma.x), near(ma.y), 1'b1, 1'b0, 1'b0);
    h = tick_hit;
    drive(near(ma.x), near(ma.y), 1'b0, 1'b0, 1'b0);
    tick_hit = h;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sexp_t s0;
    int    py;
    reset = 1'b1; hpos = '0; vpos = '0; frame_tick = 1'b0; pause = 1'b0;
    s0.v = 1'b0; s0.s = 1'b0;
    qs.push_back(s0);

    // Reset state
    repeat (3) drive(0, 0, 1'b0, 1'b0, 1'b1);
    check("rst_sprite_on", sprite_on_a, 0);
    check("rst_bounce", bounce_a, 0);
    check("rst_color", color_a, 1);
    check("rst_rom_x", rom_x_a, 0);
    check("rst_rom_y", rom_y_a, 0);

    // Reset wins over a simultaneous tick: position stays at the origin
    drive(0, 0, 1'b1, 1'b0, 1'b1);
    check("rst_over_tick_color", color_a, 1);
    drive(5, 7, 1'b0, 1'b0, 1'b0);
    check("origin_rom_x", rom_x_a, 5);
    check("origin_rom_y", rom_y_a, 7);

    // First tick: compare on that edge still uses the old origin,
    // the next compare sees pos=(1,1)
    drive(5, 7, 1'b1, 1'b0, 1'b0);
    check("tick1_same_edge_rom_x", rom_x_a, 5);
    drive(5, 7, 1'b0, 1'b0, 1'b0);
    check("tick1_rom_x", rom_x_a, 4);
    check("tick1_rom_y", rom_y_a, 6);

    // Move to (100,100) and sweep the beam across the window on its top line
    while (ma.x < 100) tick_once();
    for (int hp = 99; hp <= 230; hp++) begin
      drive(hp, 100, 1'b0, 1'b0, 1'b0);
      if (hp == 100) check("win_left_outside", sprite_on_a, 0);
      if (hp == 102) check("win_left_lit", sprite_on_a, 1);
      if (hp == 227) check("win_last_col", rom_x_a, 127);
      if (hp == 230) check("win_right_outside", sprite_on_a, 0);
    end
    // Vertical boundaries: line above and line below the sprite
    for (int k = 0; k < 4; k++) begin
      py = (k < 2) ? 99 : 228;
      drive(101, py, 1'b0, 1'b0, 1'b0);
    end

    // Right-edge bounce (and corner on the square instance)
    while (!(ma.x == 511 && ma.dx)) tick_once();
    drive(near(ma.x), near(ma.y), 1'b1, 1'b0, 1'b0);
    check("right_bounce", bounce_a, 1);
    check("right_color", color_a, 3);
    check("corner_bounce", bounce_b, 1);
    check("corner_color", color_b, 2);
    drive(515, 300, 1'b0, 1'b0, 1'b0);
    check("right_bounce_single", bounce_a, 0);
    check("corner_bounce_single", bounce_b, 0);
    check("pos_x_at_max", rom_x_a, 3);
    drive(515, 515, 1'b0, 1'b0, 1'b0);
    check("corner_pos", rom_y_b, 3);

    // Colour wrap 7 -> 1
    while (ma.col != 7) tick_once();
    do tick_once(); while (!tick_hit);
    check("color_wrap", color_a, 1);

    // Pause: three ticks with no motion, no bounce, no colour change
    for (int k = 0; k < 3; k++) begin
      drive(near(ma.x), near(ma.y), 1'b1, 1'b1, 1'b0);
      check("pause_bounce", bounce_a, 0);
      check("pause_color", color_a, 1);
      drive(near(ma.x), near(ma.y), 1'b0, 1'b0, 1'b0);
    end
    drive(ma.x, ma.y, 1'b0, 1'b0, 1'b0);
    check("pause_pos_x", rom_x_a, 0);
    check("pause_pos_y", rom_y_a, 0);
    repeat (4) tick_once();

    // Reset mid-line while the sprite is lit
    repeat (3) drive(ma.x + 1, ma.y, 1'b0, 1'b0, 1'b0);
    check("pre_reset_lit", sprite_on_a, 1);
    drive(ma.x + 1, ma.y, 1'b0, 1'b0, 1'b1);
    check("reset_midline", sprite_on_a, 0);
    drive(1, 0, 1'b0, 1'b0, 1'b0);
    check("release_hold", sprite_on_a, 0);
    drive(1, 0, 1'b0, 1'b0, 1'b0);
    check("release_fresh", sprite_on_a, 1);
    repeat (3) tick_once();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
